// File: rtl/row_col_dec_5x5.sv
// row_col_dec_5x5: readback decoder/monitor for the 5x5 DCO capacitor-array
// select code. Captures the r_all/row/col triple, rebuilds the tuning word,
// flags illegal encodings and oversized word jumps, and counts both events.
module row_col_dec_5x5 #(
  parameter int MAX      = 25,
  parameter int STEP_MAX = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [4:0]       r_all,
  input  logic [4:0]       row,
  input  logic [4:0]       col,
  output logic [4:0]       word,
  output logic             valid,
  output logic             err,
  output logic             step_err,
  output logic [CNT_W-1:0] err_cnt
);

  // stage-1 capture registers
  logic [4:0]       cap_ra_q, cap_ra_d;
  logic [4:0]       cap_row_q, cap_row_d;
  logic [4:0]       cap_col_q, cap_col_d;
  logic             cap_v_q, cap_v_d;

  // stage-2 outputs and step history
  logic [4:0]       word_q, word_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             step_err_q, step_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [4:0]       last_w_q, last_w_d;
  logic             last_v_q, last_v_d;

  // decode intermediates
  logic [2:0]       r_idx;
  logic [2:0]       c_cnt;
  logic [2:0]       row_ones;
  logic             one_hot;
  logic [5:0]       word6;
  logic [4:0]       word_dec;
  logic [4:0]       ra_exp;
  logic [5:0]       fill6;
  logic [4:0]       col_lsb;
  logic [4:0]       col_msb;
  logic             col_ok;
  logic             c_ok;
  logic             legal;
  logic             idle;
  logic [4:0]       diff;
  logic             step_big;
  logic             inc;

  // capture: register the triple whenever en is high
  always_comb begin
    cap_ra_d  = cap_ra_q;
    cap_row_d = cap_row_q;
    cap_col_d = cap_col_q;
    cap_v_d   = en;
    if (en) begin
      cap_ra_d  = r_all;
      cap_row_d = row;
      cap_col_d = col;
    end
  end

  // row index and column count; r_idx is only meaningful when row is one-hot
  always_comb begin
    r_idx    = 3'd0;
    c_cnt    = 3'd0;
    row_ones = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (cap_row_q[i]) begin
        r_idx    = 3'(i);
        row_ones = row_ones + 3'd1;
      end
      if (cap_col_q[i]) c_cnt = c_cnt + 3'd1;
    end
    one_hot = (row_ones == 3'd1);
  end

  // word reconstruction and legality of the whole triple
  always_comb begin
    word6    = 6'(r_idx) * 6'd5 + 6'(c_cnt);
    word_dec = word6[4:0];
    // rows below r are zero, row r and above are one
    ra_exp   = ~((5'd1 << r_idx) - 5'd1);
    // column fill: LSB-first on even rows, MSB-first on odd rows
    fill6    = (6'd1 << c_cnt) - 6'd1;
    col_lsb  = fill6[4:0];
    col_msb  = 5'(fill6 << (3'd5 - c_cnt));
    col_ok   = r_idx[0] ? (cap_col_q == col_msb) : (cap_col_q == col_lsb);
    // an empty column set is only word 0
    c_ok     = (c_cnt != 3'd0) || (r_idx == 3'd0);
    legal    = one_hot && (cap_ra_q == ra_exp) && col_ok && c_ok &&
               (int'(word6) <= MAX);
    idle     = (cap_ra_q == 5'd0) && (cap_row_q == 5'd0) && (cap_col_q == 5'd0);
  end

  // distance from the last legal word
  always_comb begin
    diff     = (word_dec >= last_w_q) ? (word_dec - last_w_q) : (last_w_q - word_dec);
    step_big = int'(diff) > STEP_MAX;
  end

  // stage-2 outputs and step history update
  always_comb begin
    word_d     = word_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    step_err_d = 1'b0;
    last_w_d   = last_w_q;
    last_v_d   = last_v_q;
    if (cap_v_q) begin
      if (idle) begin
        // coder reset pattern: not an error, but breaks the step history
        last_v_d = 1'b0;
      end else if (legal) begin
        word_d     = word_dec;
        valid_d    = 1'b1;
        step_err_d = last_v_q && step_big;
        last_w_d   = word_dec;
        last_v_d   = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
    // clear wins over a same-edge history update
    if (clr) last_v_d = 1'b0;
  end

  // saturating event counter; clear wins over a same-edge increment
  always_comb begin
    inc       = err_d || step_err_d;
    err_cnt_d = err_cnt_q;
    if (clr) begin
      err_cnt_d = '0;
    end else if (inc && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_ra_q   <= '0;
      cap_row_q  <= '0;
      cap_col_q  <= '0;
      cap_v_q    <= 1'b0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      step_err_q <= 1'b0;
      err_cnt_q  <= '0;
      last_w_q   <= '0;
      last_v_q   <= 1'b0;
    end else begin
      cap_ra_q   <= cap_ra_d;
      cap_row_q  <= cap_row_d;
      cap_col_q  <= cap_col_d;
      cap_v_q    <= cap_v_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      step_err_q <= step_err_d;
      err_cnt_q  <= err_cnt_d;
      last_w_q   <= last_w_d;
      last_v_q   <= last_v_d;
    end
  end

  assign word     = word_q;
  assign valid    = valid_q;
  assign err      = err_q;
  assign step_err = step_err_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_row_col_dec_5x5.sv
// Directed bench for row_col_dec_5x5 with hand-computed expectations.
module tb_row_col_dec_5x5;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic [4:0] r_all = 5'd0;
  logic [4:0] row = 5'd0;
  logic [4:0] col = 5'd0;
  logic [4:0] word;
  logic       valid;
  logic       err;
  logic       step_err;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;

  row_col_dec_5x5 #(.MAX(25), .STEP_MAX(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .r_all(r_all), .row(row), .col(col),
    .word(word), .valid(valid), .err(err), .step_err(step_err),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // check all outputs at once
  task automatic chk_all(input string tag, input logic [4:0] w, input logic v,
                         input logic e, input logic s, input logic [7:0] c);
    chk({tag, ".word"}, 32'(word), 32'(w));
    chk({tag, ".valid"}, 32'(valid), 32'(v));
    chk({tag, ".err"}, 32'(err), 32'(e));
    chk({tag, ".step_err"}, 32'(step_err), 32'(s));
    chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(c));
  endtask

  // one capture, then sample just after the output-update edge;
  // clr_v is applied on that output edge
  task automatic cap(input logic [4:0] ra, input logic [4:0] rw, input logic [4:0] cl,
                     input logic clr_v);
    @(negedge clk);
    r_all = ra; row = rw; col = cl; en = 1'b1;
    @(negedge clk);
    en = 1'b0; clr = clr_v;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    // reset state
    #12;
    chk_all("reset", 5'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // main decode and step history
    cap(5'b11110, 5'b00010, 5'b11000, 1'b0);
    chk_all("w7", 5'd7, 1'b1, 1'b0, 1'b0, 8'd0);
    cap(5'b11100, 5'b00100, 5'b00111, 1'b0);
    chk_all("w13_step", 5'd13, 1'b1, 1'b0, 1'b1, 8'd1);
    cap(5'b11000, 5'b01000, 5'b10000, 1'b0);
    chk_all("w16", 5'd16, 1'b1, 1'b0, 1'b0, 8'd1);
    cap(5'b00000, 5'b00000, 5'b00000, 1'b0);
    chk_all("idle", 5'd16, 1'b0, 1'b0, 1'b0, 8'd1);
    cap(5'b10000, 5'b10000, 5'b11111, 1'b0);
    chk_all("w25_after_idle", 5'd25, 1'b1, 1'b0, 1'b0, 8'd1);

    // boundaries (each jump exceeds the step limit)
    cap(5'b11111, 5'b00001, 5'b00000, 1'b0);
    chk_all("w0", 5'd0, 1'b1, 1'b0, 1'b1, 8'd2);
    cap(5'b11111, 5'b00001, 5'b11111, 1'b0);
    chk_all("w5", 5'd5, 1'b1, 1'b0, 1'b1, 8'd3);

    // illegal triples: word holds at 5
    cap(5'b11111, 5'b00110, 5'b00000, 1'b0);
    chk_all("ill_row", 5'd5, 1'b0, 1'b1, 1'b0, 8'd4);
    cap(5'b11111, 5'b00001, 5'b01010, 1'b0);
    chk_all("ill_col_gap", 5'd5, 1'b0, 1'b1, 1'b0, 8'd5);
    cap(5'b11110, 5'b00010, 5'b00011, 1'b0);
    chk_all("ill_fill_dir", 5'd5, 1'b0, 1'b1, 1'b0, 8'd6);
    cap(5'b11100, 5'b00100, 5'b00000, 1'b0);
    chk_all("ill_c0_r2", 5'd5, 1'b0, 1'b1, 1'b0, 8'd7);

    // en low: nothing updates
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("en0.valid", 32'(valid), 32'd0);
      chk("en0.word", 32'(word), 32'd5);
    end

    // saturation
    @(negedge clk);
    r_all = 5'b11111; row = 5'b00110; col = 5'b00000; en = 1'b1;
    repeat (300) @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("sat.err_cnt", 32'(err_cnt), 32'd255);
    cap(5'b11111, 5'b00110, 5'b00000, 1'b0);
    chk("sat_hold.err_cnt", 32'(err_cnt), 32'd255);

    // clear with a simultaneous error event
    cap(5'b11111, 5'b00110, 5'b00000, 1'b1);
    chk("clr.err_cnt", 32'(err_cnt), 32'd0);
    chk("clr.err", 32'(err), 32'd1);

    // mid-stream reset
    cap(5'b11100, 5'b00100, 5'b00111, 1'b0);
    chk_all("pre_rst_w13", 5'd13, 1'b1, 1'b0, 1'b0, 8'd0);
    cap(5'b11111, 5'b00110, 5'b00000, 1'b0);
    chk("pre_rst.err_cnt", 32'(err_cnt), 32'd1);
    @(negedge clk);
    r_all = 5'b11110; row = 5'b00010; col = 5'b11000; en = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk_all("mid_rst", 5'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    en = 1'b0;
    rst = 1'b0;
    cap(5'b10000, 5'b10000, 5'b11111, 1'b0);
    chk_all("post_rst_w25", 5'd25, 1'b1, 1'b0, 1'b0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
